reverb: RTL and testbench

REVERB -- requirements
Module: reverb

---
 rtl/reverb.sv | 154 +++++++++++++++
 tb/tb_reverb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reverb.sv
// Single-tap feedback echo over a DEPTH-sample delay line, sequenced IDLE->READ->CALC->WRITE->OUT.
// Define REVERB_CLEAR_EN to zero the whole delay line in a CLEAR state after every reset.
module reverb #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 16,
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH+FRAC-1:0]    in_sample,
  input  logic                     enable,
  input  logic [$clog2(DEPTH)-1:0] delay,
  input  logic [31:0]              feedback,
  input  logic [31:0]              wet,
  output logic                     ready,
  output logic                     out_valid,
  output logic [WIDTH+FRAC-1:0]    out_sample,
  output logic                     overrun
);
  localparam int DW = WIDTH + FRAC;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
`ifdef REVERB_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_RESET = S_CLEAR;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  localparam logic signed [PW:0] SAT_MAX = {{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN = {{(PW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]           r_state;
  logic signed [DW-1:0] r_in;
  logic signed [DW-1:0] r_tap;
  logic                 r_en;
  logic [AW-1:0]        r_delay;
  logic [AW-1:0]        r_wptr;
  logic signed [31:0]   r_fb;
  logic signed [31:0]   r_wet;
  logic signed [PW-1:0] r_fbTerm;
  logic signed [PW-1:0] r_wetTerm;
  logic [DW-1:0]        r_mem [DEPTH];
`ifdef REVERB_CLEAR_EN
  logic [AW-1:0]        r_clrAddr;
`endif

  logic [AW-1:0]        w_dEff;
  logic [AW-1:0]        w_rdAddr;
  logic signed [PW-1:0] w_fbProd;
  logic signed [PW-1:0] w_wetProd;
  logic signed [PW:0]   w_wrSum;
  logic signed [PW:0]   w_outSum;
  logic [DW-1:0]        w_wrData;
  logic                 w_memWe;
  logic [AW-1:0]        w_memAddr;
  logic [DW-1:0]        w_memData;

  function automatic logic [DW-1:0] sat(input logic signed [PW:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    else                  return v[DW-1:0];
  endfunction

  // A zero delay would read the slot about to be written, so it aliases to one sample.
  assign w_dEff    = (r_delay == '0) ? AW'(1) : r_delay;
  assign w_rdAddr  = r_wptr - w_dEff;
  assign w_fbProd  = PW'(r_tap) * PW'(r_fb);
  assign w_wetProd = PW'(r_tap) * PW'(r_wet);
  assign w_wrSum   = (PW+1)'(r_in) + (PW+1)'(r_fbTerm);
  assign w_outSum  = (PW+1)'(r_in) + (PW+1)'(r_wetTerm);
  assign w_wrData  = sat(w_wrSum);
  assign ready     = (r_state == S_IDLE);

`ifdef REVERB_CLEAR_EN
  assign w_memWe   = ((r_state == S_WRITE) && r_en) || (r_state == S_CLEAR);
  assign w_memAddr = (r_state == S_CLEAR) ? r_clrAddr : r_wptr;
  assign w_memData = (r_state == S_CLEAR) ? '0 : w_wrData;
`else
  assign w_memWe   = (r_state == S_WRITE) && r_en;
  assign w_memAddr = r_wptr;
  assign w_memData = w_wrData;
`endif

  // Delay line kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memData;
    if (r_state == S_READ) r_tap <= r_mem[w_rdAddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_wptr     <= '0;
      r_in       <= '0;
      r_en       <= 1'b0;
      r_delay    <= '0;
      r_fb       <= '0;
      r_wet      <= '0;
      r_fbTerm   <= '0;
      r_wetTerm  <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      overrun    <= 1'b0;
`ifdef REVERB_CLEAR_EN
      r_clrAddr  <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (r_state != S_IDLE)) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in    <= in_sample;
            r_en    <= enable;
            r_delay <= delay;
            r_fb    <= feedback;
            r_wet   <= wet;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_CALC;
        S_CALC: begin
          r_fbTerm  <= w_fbProd >>> FRAC;
          r_wetTerm <= w_wetProd >>> FRAC;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          if (r_en) r_wptr <= r_wptr + AW'(1);
          r_state <= S_OUT;
        end
        S_OUT: begin
          out_sample <= r_en ? sat(w_outSum) : r_in;
          out_valid  <= 1'b1;
          r_state    <= S_IDLE;
        end
`ifdef REVERB_CLEAR_EN
        S_CLEAR: begin
          r_clrAddr <= r_clrAddr + AW'(1);
          if (r_clrAddr == AW'(DEPTH - 1)) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reverb.sv
// Bench for reverb: directed samples with a reference model feeding an expected-output queue.
module tb_reverb;
  localparam int WIDTH = 24;
  localparam int FRAC  = 16;
  localparam int DEPTH = 16;
  localparam int DW    = WIDTH + FRAC;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_sample;
  logic          enable;
  logic [AW-1:0] delay;
  logic [31:0]   feedback;
  logic [31:0]   wet;
  logic          ready;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] expQ[$];
  logic signed [DW-1:0] mdlMem[DEPTH];
  int                   mdlWp;
  logic signed [DW-1:0] lastOut;

  reverb #(.WIDTH(WIDTH), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .enable(enable), .delay(delay), .feedback(feedback), .wet(wet),
    .ready(ready), .out_valid(out_valid), .out_sample(out_sample), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [79:0] obs,
                             input logic signed [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] satf(input logic signed [79:0] v);
    logic signed [79:0] hi;
    logic signed [79:0] lo;
    hi = (80'sd1 <<< (DW-1)) - 80'sd1;
    lo = -(80'sd1 <<< (DW-1));
    if (v > hi) return hi[DW-1:0];
    if (v < lo) return lo[DW-1:0];
    return v[DW-1:0];
  endfunction

  // Reference behaviour of one accepted sample; updates the model delay line.
  function automatic logic signed [DW-1:0] modelStep(input logic signed [DW-1:0] s, input logic e,
                                                     input int d, input logic signed [31:0] fb,
                                                     input logic signed [31:0] w);
    logic signed [DW-1:0] tap;
    logic signed [79:0]   p;
    int                   dd;
    if (!e) return s;
    dd  = (d == 0) ? 1 : d;
    tap = mdlMem[(mdlWp - dd + DEPTH) % DEPTH];
    p   = 80'(tap) * 80'(fb);
    mdlMem[mdlWp] = satf(80'(s) + (p >>> FRAC));
    p   = 80'(tap) * 80'(w);
    mdlWp = (mdlWp + 1) % DEPTH;
    return satf(80'(s) + (p >>> FRAC));
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("ready_timeout", 80'(ready), 80'sd1);
  endtask

  task automatic applyStimulus(input string tag, input logic signed [DW-1:0] s, input logic e,
                               input int d, input logic signed [31:0] fb,
                               input logic signed [31:0] w, input logic glitch);
    int                   k;
    logic                 readyLow;
    logic signed [DW-1:0] exp;
    waitReady();
    in_sample = s;
    enable    = e;
    delay     = AW'(d);
    feedback  = fb;
    wet       = w;
    in_valid  = 1'b1;
    expQ.push_back(modelStep(s, e, d, fb, w));
    @(negedge clk);
    in_valid  = 1'b0;
    in_sample = DW'($urandom);
    enable    = ~e;
    delay     = AW'($urandom);
    feedback  = $urandom;
    wet       = $urandom;
    k         = 1;
    readyLow  = 1'b1;
    while (!out_valid && k < 12) begin
      if (ready) readyLow = 1'b0;
      @(negedge clk);
      k++;
      in_valid = (glitch && k == 2);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 80'(k), 80'sd5);
    checkOutput({tag, "_ready_busy"}, 80'(readyLow), 80'sd1);
    checkOutput({tag, "_ready_idle"}, 80'(ready), 80'sd1);
    exp = (expQ.size() > 0) ? expQ.pop_front() : '0;
    checkOutput({tag, "_sample"}, 80'($signed(out_sample)), 80'(exp));
    lastOut = $signed(out_sample);
    @(negedge clk);
    checkOutput({tag, "_strobe_len"}, 80'(out_valid), 80'sd0);
  endtask

  initial begin
    logic signed [DW-1:0] impExp[7];
    logic signed [DW-1:0] q;
    logic signed [DW-1:0] maxV;
    logic signed [DW-1:0] minV;
    logic                 sawValid;
    int                   tgt;

    impExp = '{40'sd65536, 40'sd0, 40'sd0, 40'sd65536, 40'sd0, 40'sd0, 40'sd32768};
    q    = 40'sd1 <<< (DW-2);
    maxV = (40'sd1 <<< (DW-1)) - 40'sd1;
    minV = 40'sd1 <<< (DW-1);
    for (int i = 0; i < DEPTH; i++) mdlMem[i] = '0;
    mdlWp = 0;

    $display("[TB] start");
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; enable = 1'b0;
    delay = '0; feedback = '0; wet = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 80'(out_valid), 80'sd0);
    checkOutput("rst_out_sample", 80'($signed(out_sample)), 80'sd0);
    checkOutput("rst_overrun", 80'(overrun), 80'sd0);
    rst = 1'b0;

    // Zero the delay line through the datapath so the model and DUT agree from here on.
    for (int i = 0; i < DEPTH; i++) applyStimulus("pre", '0, 1'b1, 1, 32'sd0, 32'sd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus("imp", (i == 0) ? 40'sd65536 : 40'sd0, 1'b1, 3, 32'sd32768, 32'sd65536, 1'b0);
      checkOutput("impulse_const", 80'(lastOut), 80'(impExp[i]));
    end

    checkOutput("overrun_clear", 80'(overrun), 80'sd0);
    applyStimulus("ovr", 40'sd327680, 1'b1, 2, 32'sd49152, 32'sd16384, 1'b1);
    checkOutput("overrun_set", 80'(overrun), 80'sd1);

    for (int i = 0; i < 12; i++)
      applyStimulus("wrap", DW'((i + 1) * 1000 - 5000), 1'b1, 0, 32'sd32768, 32'sd65536, 1'b0);
    checkOutput("overrun_sticky", 80'(overrun), 80'sd1);

    applyStimulus("bypass", 40'sd777777, 1'b0, 5, 32'sd65536, 32'sd131072, 1'b0);
    checkOutput("bypass_const", 80'(lastOut), 80'sd777777);
    repeat (3) @(negedge clk);
    checkOutput("hold", 80'($signed(out_sample)), 80'sd777777);
    applyStimulus("post_bypass", '0, 1'b1, 1, 32'sd0, 32'sd65536, 1'b0);

    applyStimulus("sat_store_p", q, 1'b1, 1, 32'sd0, 32'sd0, 1'b0);
    applyStimulus("sat_pos", q, 1'b1, 1, 32'sd0, 32'sd131072, 1'b0);
    checkOutput("sat_pos_const", 80'(lastOut), 80'(maxV));
    applyStimulus("sat_store_n", -q, 1'b1, 1, 32'sd0, 32'sd0, 1'b0);
    applyStimulus("sat_neg", -q, 1'b1, 1, 32'sd0, 32'sd131072, 1'b0);
    checkOutput("sat_neg_const", 80'(lastOut), 80'(minV));

    // Abort a sample in CALC; its target slot must keep the old contents.
    tgt = mdlWp;
    waitReady();
    in_sample = 40'sd12345 <<< 16; enable = 1'b1; delay = AW'(1);
    feedback = 32'sd65536; wet = 32'sd65536; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 80'(out_valid), 80'sd0);
    checkOutput("mid_rst_out_sample", 80'($signed(out_sample)), 80'sd0);
    checkOutput("mid_rst_overrun", 80'(overrun), 80'sd0);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mid_rst_no_valid", 80'(sawValid), 80'sd0);
    mdlWp = 0;
`ifdef REVERB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) mdlMem[i] = '0;
`endif
    applyStimulus("mid_rst_slot", '0, 1'b1, (DEPTH - tgt) % DEPTH, 32'sd0, 32'sd65536, 1'b0);
    applyStimulus("resume", 40'sd4096, 1'b1, 1, 32'sd32768, 32'sd65536, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
